// File: rtl/deflate_bit_packer.sv
`default_nettype none
// ============================================================================
//  Module      : deflate_bit_packer
//  Description : Packs variable-length DEFLATE code chunks (LSB-first) into
//                32-bit output words. The stream header is preloaded into the
//                accumulator. A final chunk flushes the remaining bits in one
//                or two zero-padded beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module deflate_bit_packer #(
    parameter logic [2:0] HEADER_BITS = 3'b011,
    parameter int         CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [5:0]           in_size,
    input  logic [31:0]          in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    output logic [31:0]          out_data,
    output logic [2:0]           out_bytes,
    output logic                 out_last,
    output logic [CNT_WIDTH-1:0] out_byte_cnt,
    output logic                 size_err
);

    localparam logic [6:0]  HEADER_FILL = 7'd3;
    localparam logic [63:0] HEADER_ACC  = {61'd0, HEADER_BITS};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] acc;
    logic [63:0] acc_nxt;
    logic [6:0]  fill;
    logic [6:0]  fill_nxt;

    logic        size_ok;
    logic [5:0]  eff_size;
    logic [31:0] chunk_bits;
    logic [63:0] merged;
    logic [6:0]  total;

    logic        beat_valid;
    logic [31:0] beat_data;
    logic [2:0]  beat_bytes;
    logic        beat_last;
    logic        err_nxt;

    // Number of whole-or-partial bytes needed to carry nbits (nbits <= 32).
    function automatic logic [2:0] ceil_bytes(input logic [6:0] nbits);
        return 3'((nbits + 7'd7) >> 3);
    endfunction

    // Chunk qualification and merge of the incoming bits above the current fill.
    // An illegal size contributes no bits, so acc/fill are left untouched.
    always_comb begin
        size_ok    = (in_size <= 6'd32);
        eff_size   = size_ok ? in_size : 6'd0;
        chunk_bits = size_ok ? (in_data & ~(32'hFFFF_FFFF << in_size)) : 32'd0;
        merged     = acc | ({32'd0, chunk_bits} << fill);
        total      = fill + {1'b0, eff_size};
    end

    // Next-state, accumulator update and output-beat selection.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        fill_nxt   = fill;
        beat_valid = 1'b0;
        beat_data  = 32'd0;
        beat_bytes = 3'd0;
        beat_last  = 1'b0;
        err_nxt    = size_err;

        case (state)
            ST_RUN: begin
                if (in_valid) begin
                    if (!size_ok) begin
                        err_nxt = 1'b1;
                    end
                    if (in_last) begin
                        beat_valid = 1'b1;
                        beat_data  = merged[31:0];
                        if (total > 7'd32) begin
                            // Two-beat tail: full word now, remainder from FLUSH.
                            beat_bytes = 3'd4;
                            acc_nxt    = merged >> 32;
                            fill_nxt   = total - 7'd32;
                            state_nxt  = ST_FLUSH;
                        end else begin
                            beat_bytes = ceil_bytes(total);
                            beat_last  = 1'b1;
                            acc_nxt    = HEADER_ACC;
                            fill_nxt   = HEADER_FILL;
                        end
                    end else if (total >= 7'd32) begin
                        beat_valid = 1'b1;
                        beat_data  = merged[31:0];
                        beat_bytes = 3'd4;
                        acc_nxt    = merged >> 32;
                        fill_nxt   = total - 7'd32;
                    end else begin
                        acc_nxt  = merged;
                        fill_nxt = total;
                    end
                end
            end

            ST_FLUSH: begin
                // No backpressure exists, so a chunk arriving now is lost.
                if (in_valid) begin
                    err_nxt = 1'b1;
                end
                beat_valid = 1'b1;
                beat_data  = acc[31:0];
                beat_bytes = ceil_bytes(fill);
                beat_last  = 1'b1;
                acc_nxt    = HEADER_ACC;
                fill_nxt   = HEADER_FILL;
                state_nxt  = ST_RUN;
            end

            default: begin
                state_nxt = ST_RUN;
                acc_nxt   = HEADER_ACC;
                fill_nxt  = HEADER_FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Accumulator, registered output beat, byte counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= HEADER_ACC;
            fill         <= HEADER_FILL;
            out_valid    <= 1'b0;
            out_data     <= 32'd0;
            out_bytes    <= 3'd0;
            out_last     <= 1'b0;
            out_byte_cnt <= '0;
            size_err     <= 1'b0;
        end else begin
            acc       <= acc_nxt;
            fill      <= fill_nxt;
            out_valid <= beat_valid;
            out_data  <= beat_data;
            out_bytes <= beat_bytes;
            out_last  <= beat_last;
            size_err  <= err_nxt;
            // The total stays visible on the last beat and restarts afterwards.
            if (beat_valid) begin
                out_byte_cnt <= (out_last ? '0 : out_byte_cnt) + CNT_WIDTH'(beat_bytes);
            end else if (out_last) begin
                out_byte_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire
